// File: rtl/traffic_light_monitor.sv
// Passive monitor for the four-approach lamp-drive bus: tracks the
// green -> yellow-handover -> next-green rotation and reports lamp, conflict, order and timing faults.
module traffic_light_monitor #(
    parameter int GREEN_LEN  = 7,
    parameter int YELLOW_LEN = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       r,
    input  logic [3:0]       g,
    input  logic [3:0]       y,
    output logic             locked,
    output logic [1:0]       phase,
    output logic             in_yellow,
    output logic             err_lamp,
    output logic             err_conflict,
    output logic             err_seq,
    output logic             err_time,
    output logic             err_sticky,
    output logic [CNT_W-1:0] rotations
);

    typedef enum logic [1:0] {
        S_UNLOCKED = 2'd0,
        S_GREEN    = 2'd1,
        S_YELLOW   = 2'd2
    } state_t;

    localparam logic [7:0] GREEN_CNT  = 8'(GREEN_LEN);
    localparam logic [7:0] YELLOW_CNT = 8'(YELLOW_LEN);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_cnt;
    logic [7:0]       w_cnt_nxt;
    logic [1:0]       r_phase;
    logic [1:0]       w_phase_nxt;
    logic [1:0]       w_phase_inc;
    logic [1:0]       w_ho_idx;
    logic [3:0]       w_is_green;
    logic [3:0]       w_is_ho;
    logic             w_lamp_bad;
    logic             w_conflict;
    logic             w_seq;
    logic             w_time;
    logic             w_rot_inc;

    logic             r_locked;
    logic             r_in_yellow;
    logic             r_err_lamp;
    logic             r_err_conflict;
    logic             r_err_seq;
    logic             r_err_time;
    logic             r_err_sticky;
    logic [CNT_W-1:0] r_rotations;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Decode each legal lamp pattern exactly, including the red lines.
    for (genvar k = 0; k < 4; k++) begin : g_pat
        localparam logic [3:0] OH   = 4'(1 << k);
        localparam logic [3:0] OHHO = 4'(1 << k) | 4'(1 << ((k + 1) % 4));
        assign w_is_green[k] = (g == OH) && (y == 4'b0000) && (r == ~OH);
        assign w_is_ho[k]    = (g == 4'b0000) && (y == OHHO) && (r == ~OHHO);
    end

    assign w_lamp_bad  = |((r & g) | (r & y) | (g & y) | ~(r | g | y));
    assign w_conflict  = ((g & (g - 4'd1)) != 4'd0) || ((g != 4'd0) && (y != 4'd0));
    assign w_phase_inc = r_phase + 2'd1;

    always_comb begin
        w_ho_idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (w_is_ho[k]) w_ho_idx = 2'(k);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_UNLOCKED;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_UNLOCKED: if (|w_is_ho) w_state_nxt = S_YELLOW;
            S_YELLOW: begin
                if (w_is_ho[r_phase])               w_state_nxt = S_YELLOW;
                else if (w_is_green[w_phase_inc])   w_state_nxt = S_GREEN;
                else                                w_state_nxt = S_UNLOCKED;
            end
            S_GREEN: begin
                if (w_is_green[r_phase])            w_state_nxt = S_GREEN;
                else if (w_is_ho[r_phase])          w_state_nxt = S_YELLOW;
                else                                w_state_nxt = S_UNLOCKED;
            end
            default: w_state_nxt = S_UNLOCKED;
        endcase
    end

    // Overlong phases are flagged on the single step where cnt passes LEN.
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_phase_nxt = r_phase;
        w_seq       = 1'b0;
        w_time      = 1'b0;
        w_rot_inc   = 1'b0;
        case (r_state)
            S_UNLOCKED: begin
                if (|w_is_ho) begin
                    w_phase_nxt = w_ho_idx;
                    w_cnt_nxt   = 8'd1;
                end
            end
            S_YELLOW: begin
                if (w_is_ho[r_phase]) begin
                    w_cnt_nxt = sat_inc8(r_cnt);
                    w_time    = (r_cnt == YELLOW_CNT);
                end else if (w_is_green[w_phase_inc]) begin
                    w_time      = (r_cnt != YELLOW_CNT);
                    w_cnt_nxt   = 8'd1;
                    w_phase_nxt = w_phase_inc;
                    w_rot_inc   = (r_phase == 2'd3);
                end else begin
                    w_seq = 1'b1;
                end
            end
            S_GREEN: begin
                if (w_is_green[r_phase]) begin
                    w_cnt_nxt = sat_inc8(r_cnt);
                    w_time    = (r_cnt == GREEN_CNT);
                end else if (w_is_ho[r_phase]) begin
                    w_time    = (r_cnt != GREEN_CNT);
                    w_cnt_nxt = 8'd1;
                end else begin
                    w_seq = 1'b1;
                end
            end
            default: w_seq = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt          <= 8'd0;
            r_phase        <= 2'd0;
            r_locked       <= 1'b0;
            r_in_yellow    <= 1'b0;
            r_err_lamp     <= 1'b0;
            r_err_conflict <= 1'b0;
            r_err_seq      <= 1'b0;
            r_err_time     <= 1'b0;
            r_err_sticky   <= 1'b0;
            r_rotations    <= '0;
        end else begin
            r_cnt          <= w_cnt_nxt;
            r_phase        <= w_phase_nxt;
            r_locked       <= (w_state_nxt != S_UNLOCKED);
            r_in_yellow    <= (w_state_nxt == S_YELLOW);
            r_err_lamp     <= w_lamp_bad;
            r_err_conflict <= w_conflict;
            r_err_seq      <= w_seq;
            r_err_time     <= w_time;
            r_err_sticky   <= r_err_sticky | w_lamp_bad | w_conflict | w_seq | w_time;
            if (w_rot_inc && !(&r_rotations)) r_rotations <= r_rotations + CNT_W'(1);
        end
    end

    assign locked       = r_locked;
    assign phase        = r_phase;
    assign in_yellow    = r_in_yellow;
    assign err_lamp     = r_err_lamp;
    assign err_conflict = r_err_conflict;
    assign err_seq      = r_err_seq;
    assign err_time     = r_err_time;
    assign err_sticky   = r_err_sticky;
    assign rotations    = r_rotations;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: legal rotation stream, a table of fault
// and timing vectors, and hand-written reset/relock sequences.
module tb_traffic_light_monitor;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       r, g, y;
    logic             locked, in_yellow;
    logic [1:0]       phase;
    logic             err_lamp, err_conflict, err_seq, err_time, err_sticky;
    logic [CNT_W-1:0] rotations;

    traffic_light_monitor #(.GREEN_LEN(7), .YELLOW_LEN(1), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .r(r), .g(g), .y(y),
        .locked(locked), .phase(phase), .in_yellow(in_yellow),
        .err_lamp(err_lamp), .err_conflict(err_conflict), .err_seq(err_seq),
        .err_time(err_time), .err_sticky(err_sticky), .rotations(rotations)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             lk;
        logic [1:0]       ph;
        logic             iy;
        logic             lamp;
        logic             conf;
        logic             seq;
        logic             tm;
        logic             st;
        logic [CNT_W-1:0] rot;
    } out_t;

    typedef struct {
        logic [11:0] pat;
        int          reps;
        out_t        exp;
        string       name;
    } vec_t;

    out_t sb_q[$];
    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [11:0] GRN(input int k);
        logic [3:0] oh;
        oh = 4'(1 << k);
        return {~oh, oh, 4'b0000};
    endfunction

    function automatic logic [11:0] HO(input int k);
        logic [3:0] oh;
        oh = 4'(1 << k) | 4'(1 << ((k + 1) % 4));
        return {~oh, 4'b0000, oh};
    endfunction

    function automatic out_t mk(input logic lk, input int ph, input logic iy, input logic lamp,
                                input logic conf, input logic seq, input logic tm,
                                input logic st, input int rot);
        out_t o;
        o.lk = lk; o.ph = 2'(ph); o.iy = iy; o.lamp = lamp; o.conf = conf;
        o.seq = seq; o.tm = tm; o.st = st; o.rot = CNT_W'(rot);
        return o;
    endfunction

    task automatic check(input string nm);
        out_t act, e;
        act = {locked, phase, in_yellow, err_lamp, err_conflict, err_seq, err_time, err_sticky, rotations};
        e   = sb_q.pop_front();
        n_cmp++;
        if (act !== e) begin
            n_bad++;
            $display("FAIL %s: got lk=%b ph=%0d iy=%b lamp=%b conf=%b seq=%b tm=%b st=%b rot=%0d, want lk=%b ph=%0d iy=%b lamp=%b conf=%b seq=%b tm=%b st=%b rot=%0d",
                     nm, act.lk, act.ph, act.iy, act.lamp, act.conf, act.seq, act.tm, act.st, act.rot,
                     e.lk, e.ph, e.iy, e.lamp, e.conf, e.seq, e.tm, e.st, e.rot);
        end
    endtask

    task automatic drive(input logic [11:0] pat, input logic rst_v, input out_t exp, input string nm);
        {r, g, y} = pat;
        rst       = rst_v;
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        check(nm);
    endtask

    initial begin
        rst = 1'b1;
        {r, g, y} = 12'hF00;
        @(posedge clk);
        #1;
        drive(12'hF00, 1'b1, mk(0,0,0,0,0,0,0,0,0), "reset");

        // Legal rotation stream starting at GREEN(0)
        for (int n = 0; n < 130; n++) begin
            int a, p;
            a = (n / 8) % 4;
            p = n % 8;
            drive((p == 7) ? HO(a) : GRN(a), 1'b0,
                  mk(n >= 7, a, p == 7, 0, 0, 0, 0, 0, n / 32), "legal_stream");
        end

        tbl.push_back('{GRN(0), 2, mk(1,0,0,0,0,0,0,0,4), "green0_pre"});
        tbl.push_back('{{4'b1100, 4'b0011, 4'b0000}, 1, mk(0,0,0,0,1,1,0,1,4), "two_greens"});
        tbl.push_back('{GRN(0), 3, mk(0,0,0,0,0,0,0,1,4), "unlocked_hold"});
        tbl.push_back('{HO(0), 1, mk(1,0,1,0,0,0,0,1,4), "relock_ho0"});
        tbl.push_back('{GRN(1), 5, mk(1,1,0,0,0,0,0,1,4), "short_green1"});
        tbl.push_back('{HO(1), 1, mk(1,1,1,0,0,0,1,1,4), "short_green_ho"});
        tbl.push_back('{GRN(2), 7, mk(1,2,0,0,0,0,0,1,4), "green2"});
        tbl.push_back('{HO(2), 1, mk(1,2,1,0,0,0,0,1,4), "ho2"});
        tbl.push_back('{GRN(3), 7, mk(1,3,0,0,0,0,0,1,4), "green3"});
        tbl.push_back('{HO(3), 1, mk(1,3,1,0,0,0,0,1,4), "ho3"});
        tbl.push_back('{GRN(0), 7, mk(1,0,0,0,0,0,0,1,5), "green0_rot5"});
        tbl.push_back('{HO(0), 1, mk(1,0,1,0,0,0,0,1,5), "ho0"});
        tbl.push_back('{GRN(1), 7, mk(1,1,0,0,0,0,0,1,5), "long_green_a"});
        tbl.push_back('{GRN(1), 1, mk(1,1,0,0,0,0,1,1,5), "long_green_8th"});
        tbl.push_back('{GRN(1), 2, mk(1,1,0,0,0,0,0,1,5), "long_green_quiet"});
        tbl.push_back('{HO(1), 1, mk(1,1,1,0,0,0,1,1,5), "long_green_ho"});
        tbl.push_back('{GRN(2), 7, mk(1,2,0,0,0,0,0,1,5), "green2_b"});
        tbl.push_back('{HO(2), 1, mk(1,2,1,0,0,0,0,1,5), "ho2_b"});
        tbl.push_back('{GRN(3), 7, mk(1,3,0,0,0,0,0,1,5), "green3_b"});
        tbl.push_back('{HO(3), 1, mk(1,3,1,0,0,0,0,1,5), "ho3_b"});
        tbl.push_back('{GRN(0), 3, mk(1,0,0,0,0,0,0,1,6), "green0_rot6"});
        tbl.push_back('{{4'b1010, 4'b0000, 4'b0101}, 1, mk(0,0,0,0,0,1,0,1,6), "skip_approach"});
        tbl.push_back('{GRN(0), 2, mk(0,0,0,0,0,0,0,1,6), "unlocked_hold2"});
        tbl.push_back('{HO(2), 1, mk(1,2,1,0,0,0,0,1,6), "relock_ho2"});
        tbl.push_back('{GRN(3), 7, mk(1,3,0,0,0,0,0,1,6), "green3_c"});
        tbl.push_back('{HO(3), 1, mk(1,3,1,0,0,0,0,1,6), "yellow_1st"});
        tbl.push_back('{HO(3), 1, mk(1,3,1,0,0,0,1,1,6), "yellow_over"});
        tbl.push_back('{HO(3), 1, mk(1,3,1,0,0,0,0,1,6), "yellow_quiet"});
        tbl.push_back('{GRN(0), 1, mk(1,0,0,0,0,0,1,1,7), "long_yellow_exit"});

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].reps; k++) begin
                drive(tbl[i].pat, 1'b0, tbl[i].exp, tbl[i].name);
            end
        end

        // Lamp fault while locked, relock, then mid-run reset
        drive({4'b1111, 4'b0001, 4'b0000}, 1'b0, mk(0,0,0,1,0,1,0,1,7), "lamp_fault");
        drive(HO(0), 1'b0, mk(1,0,1,0,0,0,0,1,7), "relock_after_lamp");
        for (int k = 0; k < 3; k++) drive(GRN(1), 1'b0, mk(1,1,0,0,0,0,0,1,7), "green1_pre_rst");
        drive(GRN(1), 1'b1, mk(0,0,0,0,0,0,0,0,0), "mid_reset");
        drive(GRN(1), 1'b0, mk(0,0,0,0,0,0,0,0,0), "post_reset_unlocked");
        drive(HO(3), 1'b0, mk(1,3,1,0,0,0,0,0,0), "post_reset_lock");
        drive(GRN(0), 1'b0, mk(1,0,0,0,0,0,0,0,1), "post_reset_rot");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
